// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch bus: request/address out, ready/data back in the same cycle.
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage PC owner: issues imem fetches, applies stalls/redirects, drives IF/ID flushes
// and keeps a one-entry skid buffer for an instruction returning during a stall.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic                   clk,
  input  logic                   reset,
  pc_sequencer_if.master         imem_bus,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_addr,
  output logic                   if_valid,
  output logic [31:0]            inst_if,
  output logic [31:0]            pc_if,
  output logic                   flush_ifid,
  output logic                   flush_idex,
  output logic                   trap_misalign,
  output logic [31:0]            bad_addr
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_KILL = 2'd2;

  logic [1:0]  fsm_q, fsm_d;
  logic [31:0] pc_q, pc_d;
  logic        pending_q, pending_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] saved_target_q, saved_target_d;
  logic [31:0] bad_addr_q, bad_addr_d;

  logic        req, accept, valid_c, misalign;
  logic [31:0] target;

  // Request generation, handshake, redirect/stall priority and next-state selection
  always_comb begin
    fsm_d          = fsm_q;
    pc_d           = pc_q;
    skid_valid_d   = skid_valid_q;
    skid_inst_d    = skid_inst_q;
    skid_pc_d      = skid_pc_q;
    saved_target_d = saved_target_q;
    bad_addr_d     = bad_addr_q;
    valid_c        = 1'b0;
    misalign       = redirect_valid && (redirect_addr[1:0] != 2'b00);
    target         = misalign ? TRAP_VECTOR : redirect_addr;

    case (fsm_q)
      ST_RUN:  req = pending_q | (!stall & !skid_valid_q);
      ST_KILL: req = 1'b1;
      default: req = 1'b0;
    endcase
    accept    = req & imem_bus.imem_ready;
    // Address is held while not accepted, so the request stays outstanding next cycle
    pending_d = req & !imem_bus.imem_ready;

    if (redirect_valid) begin
      // Redirect wins over everything: drop the skid entry and any fetch in flight
      skid_valid_d = 1'b0;
      if (misalign) bad_addr_d = redirect_addr;
      if (!req || accept) begin
        pc_d  = target;
        fsm_d = ST_RUN;
      end else begin
        // The old fetch must still complete on the bus; remember where to go after it
        saved_target_d = target;
        fsm_d          = ST_KILL;
      end
    end else begin
      case (fsm_q)
        ST_BOOT: fsm_d = ST_RUN;
        ST_RUN: begin
          if (accept) begin
            pc_d = pc_q + 32'd4;
            if (stall) begin
              skid_valid_d = 1'b1;
              skid_inst_d  = imem_bus.imem_rdata;
              skid_pc_d    = pc_q;
            end else begin
              valid_c = 1'b1;
            end
          end else if (skid_valid_q && !stall) begin
            valid_c      = 1'b1;
            skid_valid_d = 1'b0;
          end
        end
        ST_KILL: begin
          if (accept) begin
            pc_d  = saved_target_q;
            fsm_d = ST_RUN;
          end
        end
        default: fsm_d = ST_BOOT;
      endcase
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q          <= ST_BOOT;
      pc_q           <= RESET_VECTOR;
      pending_q      <= 1'b0;
      skid_valid_q   <= 1'b0;
      skid_inst_q    <= 32'h0;
      skid_pc_q      <= 32'h0;
      saved_target_q <= 32'h0;
      bad_addr_q     <= 32'h0;
    end else begin
      fsm_q          <= fsm_d;
      pc_q           <= pc_d;
      pending_q      <= pending_d;
      skid_valid_q   <= skid_valid_d;
      skid_inst_q    <= skid_inst_d;
      skid_pc_q      <= skid_pc_d;
      saved_target_q <= saved_target_d;
      bad_addr_q     <= bad_addr_d;
    end
  end

  assign imem_bus.imem_req  = req;
  assign imem_bus.imem_addr = pc_q;
  assign if_valid           = valid_c;
  // Replay presents the skid entry; otherwise the instruction comes straight off the bus
  assign pc_if              = skid_valid_q ? skid_pc_q : pc_q;
  assign inst_if            = !valid_c ? 32'h0 : (skid_valid_q ? skid_inst_q : imem_bus.imem_rdata);
  // Flushes are gated by reset so every output is quiet while reset is held
  assign flush_ifid         = redirect_valid & !reset;
  assign flush_idex         = redirect_valid & !reset;
  assign trap_misalign      = misalign & !reset;
  assign bad_addr           = bad_addr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; memory returns {16'hC0DE, addr[15:0]} as the instruction.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        stall, redirect_valid;
  logic [31:0] redirect_addr;
  logic        if_valid, flush_ifid, flush_idex, trap_misalign;
  logic [31:0] inst_if, pc_if, bad_addr;
  int checks = 0;
  int errors = 0;

  pc_sequencer_if bus();
  assign bus.imem_rdata = {16'hC0DE, bus.imem_addr[15:0]};

  pc_sequencer dut (
    .clk(clk), .reset(reset), .imem_bus(bus), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .if_valid(if_valid), .inst_if(inst_if), .pc_if(pc_if),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .trap_misalign(trap_misalign), .bad_addr(bad_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // Move to the next cycle: inputs change just after the falling edge, checks 1ns later
  task automatic cyc(input logic s, input logic rdy, input logic rv, input logic [31:0] ra);
    @(negedge clk);
    stall = s; bus.imem_ready = rdy; redirect_valid = rv; redirect_addr = ra;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_addr = 32'h0; bus.imem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", bus.imem_addr); end
    checks++; if ({if_valid, flush_ifid, flush_idex, trap_misalign} !== 4'b0) begin errors++; $display("FAIL rst_flags: got %b want 0000", {if_valid, flush_ifid, flush_idex, trap_misalign}); end
    checks++; if (inst_if !== 32'h0 || pc_if !== 32'h0 || bad_addr !== 32'h0) begin errors++; $display("FAIL rst_data: got inst %h pc %h bad %h want 0", inst_if, pc_if, bad_addr); end
  endtask

  task automatic test_boot_fetch();
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL boot_req: got %b want 0", bus.imem_req); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h0);
      checks++; if (if_valid !== 1'b1 || pc_if !== 32'(i*4) || inst_if !== (32'hC0DE_0000 | 32'(i*4)))
        begin errors++; $display("FAIL boot_fetch%0d: got v %b pc %h inst %h want v 1 pc %h", i, if_valid, pc_if, inst_if, i*4); end
    end
  endtask

  task automatic test_stall();
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (pc_if !== 32'hC || if_valid !== 1'b1) begin errors++; $display("FAIL pre_stall: got pc %h v %b want c 1", pc_if, if_valid); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 32'h0);
      checks++; if (bus.imem_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL stall%0d: got req %b v %b want 0 0", i, bus.imem_req, if_valid); end
    end
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (if_valid !== 1'b1 || pc_if !== 32'h10 || inst_if !== 32'hC0DE_0010) begin errors++; $display("FAIL stall_release: got v %b pc %h inst %h want 1 10 c0de0010", if_valid, pc_if, inst_if); end
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (if_valid !== 1'b1 || pc_if !== 32'h14) begin errors++; $display("FAIL stall_next: got v %b pc %h want 1 14", if_valid, pc_if); end
  endtask

  task automatic test_pending_skid();
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (pc_if !== 32'h1C) begin errors++; $display("FAIL skid_lead: got pc %h want 1c", pc_if); end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'h0);
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h20 || if_valid !== 1'b0) begin errors++; $display("FAIL pend%0d: got req %b addr %h v %b want 1 20 0", i, bus.imem_req, bus.imem_addr, if_valid); end
    end
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    checks++; if (bus.imem_req !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL skid_cap: got req %b v %b want 1 0", bus.imem_req, if_valid); end
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    checks++; if (bus.imem_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL skid_hold: got req %b v %b want 0 0", bus.imem_req, if_valid); end
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (bus.imem_req !== 1'b0 || if_valid !== 1'b1 || pc_if !== 32'h20 || inst_if !== 32'hC0DE_0020) begin errors++; $display("FAIL skid_replay: got req %b v %b pc %h inst %h want 0 1 20 c0de0020", bus.imem_req, if_valid, pc_if, inst_if); end
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (bus.imem_addr !== 32'h24 || if_valid !== 1'b1 || pc_if !== 32'h24) begin errors++; $display("FAIL skid_after: got addr %h v %b pc %h want 24 1 24", bus.imem_addr, if_valid, pc_if); end
  endtask

  task automatic test_redirect_kill();
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.imem_addr !== 32'h30 || bus.imem_req !== 1'b1) begin errors++; $display("FAIL kill_pend: got addr %h req %b want 30 1", bus.imem_addr, bus.imem_req); end
    cyc(1'b0, 1'b0, 1'b1, 32'h80);
    checks++; if (flush_ifid !== 1'b1 || flush_idex !== 1'b1 || if_valid !== 1'b0 || trap_misalign !== 1'b0) begin errors++; $display("FAIL kill_flush: got %b%b v %b trap %b want 11 0 0", flush_ifid, flush_idex, if_valid, trap_misalign); end
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (flush_ifid !== 1'b0 || flush_idex !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h30) begin errors++; $display("FAIL kill_wait: got fl %b%b req %b addr %h want 00 1 30", flush_ifid, flush_idex, bus.imem_req, bus.imem_addr); end
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (if_valid !== 1'b0 || bus.imem_addr !== 32'h30) begin errors++; $display("FAIL kill_discard: got v %b addr %h want 0 30", if_valid, bus.imem_addr); end
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (if_valid !== 1'b1 || pc_if !== 32'h80 || inst_if !== 32'hC0DE_0080) begin errors++; $display("FAIL kill_target: got v %b pc %h inst %h want 1 80 c0de0080", if_valid, pc_if, inst_if); end
  endtask

  task automatic test_misalign();
    cyc(1'b0, 1'b1, 1'b1, 32'h102);
    checks++; if (trap_misalign !== 1'b1 || flush_ifid !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL mis_pulse: got trap %b fl %b v %b want 1 1 0", trap_misalign, flush_ifid, if_valid); end
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (trap_misalign !== 1'b0 || bad_addr !== 32'h102) begin errors++; $display("FAIL mis_bad: got trap %b bad %h want 0 102", trap_misalign, bad_addr); end
    checks++; if (bus.imem_addr !== 32'h100 || if_valid !== 1'b1 || pc_if !== 32'h100) begin errors++; $display("FAIL mis_trapvec: got addr %h v %b pc %h want 100 1 100", bus.imem_addr, if_valid, pc_if); end
  endtask

  task automatic test_redirect_stall();
    cyc(1'b1, 1'b1, 1'b1, 32'h200);
    checks++; if (flush_idex !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL rs_flush: got fl %b v %b want 1 0", flush_idex, if_valid); end
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (if_valid !== 1'b1 || pc_if !== 32'h200) begin errors++; $display("FAIL rs_target: got v %b pc %h want 1 200", if_valid, pc_if); end
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 32'h300);
    checks++; if (bus.imem_req !== 1'b0 || flush_ifid !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL rs_drop: got req %b fl %b v %b want 0 1 0", bus.imem_req, flush_ifid, if_valid); end
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h300 || if_valid !== 1'b1 || pc_if !== 32'h300) begin errors++; $display("FAIL rs_noreplay: got req %b addr %h v %b pc %h want 1 300 1 300", bus.imem_req, bus.imem_addr, if_valid, pc_if); end
  endtask

  task automatic test_wrap();
    cyc(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (if_valid !== 1'b1 || pc_if !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top: got v %b pc %h want 1 fffffffc", if_valid, pc_if); end
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (if_valid !== 1'b1 || pc_if !== 32'h0 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_zero: got v %b pc %h addr %h want 1 0 0", if_valid, pc_if, bus.imem_addr); end
  endtask

  task automatic test_reset_mid_kill();
    cyc(1'b0, 1'b0, 1'b1, 32'h400);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin errors++; $display("FAIL mk_kill: got req %b addr %h want 1 4", bus.imem_req, bus.imem_addr); end
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 || pc_if !== 32'h0 || if_valid !== 1'b0 || bad_addr !== 32'h0) begin errors++; $display("FAIL mk_async: got req %b addr %h pc %h v %b bad %h want 0 0 0 0 0", bus.imem_req, bus.imem_addr, pc_if, if_valid, bad_addr); end
    @(negedge clk); bus.imem_ready = 1'b1;
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL mk_boot: got req %b want 0", bus.imem_req); end
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (if_valid !== 1'b1 || pc_if !== 32'h0) begin errors++; $display("FAIL mk_first: got v %b pc %h want 1 0", if_valid, pc_if); end
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (if_valid !== 1'b1 || pc_if !== 32'h4) begin errors++; $display("FAIL mk_second: got v %b pc %h want 1 4", if_valid, pc_if); end
  endtask

  initial begin
    test_reset();
    test_boot_fetch();
    test_stall();
    test_pending_skid();
    test_redirect_kill();
    test_misalign();
    test_redirect_stall();
    test_wrap();
    test_reset_mid_kill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage controller that owns the program counter and sequences instruction fetch for the RISC-V pipeline. It issues requests to instruction memory with a req/ready handshake and advances the PC by 4. It applies load-use stalls from the hazard unit and redirects from EX (taken branch, JAL/JALR), and generates the IF/ID and ID/EX flushes. A one-entry skid buffer holds an instruction that returns while the pipeline is stalled.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset
- TRAP_VECTOR, 32'h0000_0100, fetch target used when a redirect address is misaligned
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state immediately
- stall  in  1  hazard unit: IF/ID must hold this cycle
- redirect_valid  in  1  EX: PC must change to redirect_addr
- redirect_addr  in  32  redirect target
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address
- imem_ready  in  1  request accepted; imem_rdata valid in the same cycle
- imem_rdata  in  32  fetched instruction
- if_valid  out  1  inst_if/pc_if valid for IF/ID write this cycle
- inst_if  out  32  instruction to IF/ID
- pc_if  out  32  PC of inst_if
- flush_ifid  out  1  clear IF/ID
- flush_idex  out  1  clear ID/EX
- trap_misalign  out  1  one-cycle pulse on a misaligned redirect
- bad_addr  out  32  last misaligned redirect_addr, held until the next one

## Operation
- State is {pc, fsm ∈ BOOT/RUN/KILL, pending, skid_valid, skid_inst, skid_pc, saved_target, bad_addr}.
- Reset values:
  - pc = RESET_VECTOR, fsm = BOOT, pending, skid_valid and bad_addr = 0.
  - All outputs are 0 except imem_addr and pc_if, which equal RESET_VECTOR.
- A fetch is accepted when imem_req & imem_ready.
- pending is registered: imem_req & !imem_ready. While pending = 1, imem_req stays 1 and imem_addr is held.
- Effective target = redirect_addr if redirect_addr[1:0] == 0, else TRAP_VECTOR.
  - In the misaligned case, trap_misalign = 1 in the same cycle, and bad_addr <= redirect_addr.
- Priority: redirect > stall > advance.
- BOOT: imem_req = 0 for exactly one cycle, then RUN.
- RUN:
  - imem_req = pending | (!stall & !skid_valid). imem_addr = pc.
  - On accept with no redirect and no stall: if_valid = 1, inst_if = imem_rdata, pc_if = pc, pc <= pc+4.
  - On accept with stall = 1 and no redirect: if_valid = 0. The skid buffer captures rdata and pc, and pc <= pc+4.
  - Skid replay: with skid_valid = 1 and stall = 0, the block presents the skid contents with if_valid = 1, clears skid_valid, and issues no new request that cycle.
- Redirect (any state): flush_ifid = flush_idex = 1 combinationally, if_valid = 0, and skid_valid <= 0.
  - If no request is outstanding, or the outstanding request is accepted this cycle: pc <= target, fsm = RUN.
  - Otherwise: saved_target <= target, fsm = KILL.
- KILL:
  - imem_req = 1 at the old address. if_valid = 0 and the returned data is discarded.
  - On accept: pc <= saved_target, fsm = RUN.
  - A redirect in KILL overwrites saved_target and asserts both flushes.
- pc arithmetic: 32-bit, wraps modulo 2^32. 32'hFFFF_FFFC + 4 gives 0, with no flag.

## Timing
- Reset is asynchronous. Outputs take their reset values without waiting for a clock edge.
- First request: in the second cycle after reset deasserts (BOOT takes one cycle).
- Fetch latency: the cycle with imem_ready = 1 is the cycle with if_valid = 1 (0 cycles). With ready held high, one instruction per cycle.
- Redirect penalty: the target is requested in the cycle after redirect_valid (one cycle later than that if the block passes through KILL).
- Flushes and trap_misalign are combinational from redirect_valid and do not depend on stall or imem_ready.
- Stall and redirect in the same cycle: the redirect wins, and the skid buffer and the current fetch are dropped.
- Stall held high for N cycles with skid_valid = 1: no requests are issued, and pc and the skid buffer are frozen.

## Test plan
- Reset, then reset released with imem_ready = 1:
  - no request in the BOOT cycle;
  - then pc_if = 0, 4, 8 on consecutive cycles, with if_valid = 1 each cycle.
- Stall at pc = 0x10 with ready = 1 and no pending request:
  - imem_req = 0 and if_valid = 0 for 3 cycles;
  - after release, pc_if = 0x10 is delivered once with no duplicate or skip.
- ready low for 2 cycles at 0x20, then stall rises during the pending request and ready arrives:
  - the instruction goes to the skid buffer;
  - after the stall drops, it is replayed with pc_if = 0x20, followed by a fetch of 0x24.
- Redirect to 0x80 while 0x30 is pending:
  - both flushes pulse for one cycle and the FSM enters KILL;
  - the 0x30 data is discarded;
  - the next accepted fetch is 0x80, which gives if_valid = 1 with pc_if = 0x80.
- Redirect to 0x102:
  - trap_misalign pulses and bad_addr = 0x102;
  - the next fetch address is TRAP_VECTOR (0x100).
- Reset asserted mid-KILL:
  - outputs go to their reset values immediately;
  - after release the block restarts at RESET_VECTOR and saved_target is ignored.
